branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16 (power of 2, 4..256), the number of 2-bit predictor counters; IDX = log2(BHT_ENTRIES).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have if_pc  input  32  fetch-stage PC used for prediction lookup.
REQ-005 SHALL have pred_taken  output  1  combinational prediction for if_pc.
REQ-006 SHALL have ex_valid  input  1  the EX-stage instruction is valid.
REQ-007 SHALL have ex_is_branch  input  1  the EX instruction is a conditional branch.
REQ-008 SHALL have ex_is_jump  input  1  the EX instruction is JAL/JALR.
REQ-009 SHALL have ex_funct3  input  3  branch funct3.
REQ-010 SHALL have ex_pc  input  32  PC of the EX instruction.
REQ-011 SHALL have ex_target  input  32  computed branch/jump target.
REQ-012 SHALL have ex_pred_taken  input  1  prediction carried from IF with the instruction.
REQ-013 SHALL have br_less, br_equal  input  1 each  comparator flags for the EX operands.
REQ-014 SHALL have br_unsigned  output  1  comparator mode select, driven back to the comparator.
REQ-015 SHALL have redirect_valid  output  1  registered one-cycle PC redirect and flush pulse.
REQ-016 SHALL have redirect_pc  output  32  registered redirect address.
REQ-017 SHALL have illegal_br  output  1  registered one-cycle pulse for a branch with funct3 010 or 011.
REQ-018 SHALL have mispredict_cnt  output  16  saturating count of redirects.

Function
REQ-019 br_unsigned SHALL equal ex_funct3[1], combinationally, regardless of ex_valid.
REQ-020 A resolution SHALL occur in a cycle when ex_valid=1, state=IDLE, and (ex_is_branch or ex_is_jump); ex_is_jump SHALL take priority when both are set.
REQ-021 Actual outcome: 000 taken=br_equal; 001 taken=!br_equal; 100/110 taken=br_less; 101/111 taken=!br_less; 010/011 taken=0 and illegal_br pulses on the next cycle.
REQ-022 A branch SHALL mispredict when taken != ex_pred_taken; redirect_pc = taken ? ex_target : ex_pc+4 (mod 2^32, wrap at 0xFFFFFFFC -> 0x00000000).
REQ-023 A jump SHALL always redirect to {ex_target[31:1],1'b0}, SHALL count as a redirect, and SHALL NOT update the BHT.
REQ-024 Latency: redirect_valid, redirect_pc, and illegal_br SHALL appear exactly 1 cycle after the resolving cycle, each held for exactly 1 cycle.
REQ-025 The FSM SHALL have states IDLE, SHADOW1, and SHADOW2: a cycle with a redirect moves IDLE->SHADOW1; then SHADOW1->SHADOW2->IDLE unconditionally.
REQ-026 In SHADOW1/SHADOW2, EX inputs SHALL be ignored: no redirect, no BHT update, no count, no illegal_br.
REQ-027 The BHT SHALL be indexed by pc[IDX+1:2] and hold 2-bit saturating counters; pred_taken = counter[if_pc index][1].
REQ-028 Every resolved conditional branch, including illegal ones treated as not-taken, SHALL update its counter at the end of the resolving cycle: taken -> +1 saturating at 3; not-taken -> -1 saturating at 0.
REQ-029 When a lookup and an update hit the same index in one cycle, pred_taken SHALL reflect the pre-update value, with no bypass.
REQ-030 mispredict_cnt SHALL increment by 1 per redirect, saturating at 0xFFFF.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously set all BHT counters to 2'b01, state to IDLE, redirect_valid=0, redirect_pc=0, illegal_br=0, and mispredict_cnt=0.
REQ-032 A reset asserted while in SHADOW1/SHADOW2 or with a redirect pending SHALL discard it; the first cycle after release SHALL be IDLE with no redirect.

Verification
REQ-033 After reset, a BEQ at pc=0x100 with br_equal=1, ex_pred_taken=0, and ex_target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200, mispredict_cnt=1, and pred_taken for if_pc=0x100 becomes 1.
REQ-034 A BGEU (funct3=111) with br_less=0 and ex_pred_taken=1 -> br_unsigned=1, no redirect, and the counter at that index increments from 2 to 3, then stays 3 on a repeat.
REQ-035 A mispredicted branch, followed in the next two cycles by valid mispredicting branches -> exactly one redirect_valid pulse, and mispredict_cnt increases by 1 only.
REQ-036 A BNE at pc=0xFFFFFFFC with br_equal=1 and ex_pred_taken=1 -> redirect_pc=0x00000000.
REQ-037 funct3=010 with ex_pred_taken=0 -> illegal_br pulses 1 cycle and there is no redirect; with mispredict_cnt preset to 0xFFFF by repeated redirects, one more redirect leaves it at 0xFFFF.
REQ-038 rst_n asserted in SHADOW1 -> outputs clear immediately, and a mispredicted branch in the first cycle after release redirects normally.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Fetch-lookup, EX-resolution and redirect signals between the pipeline and the branch resolver.
interface branch_resolver_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        br_less;
    logic        br_equal;
    logic        br_unsigned;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic [15:0] mispredict_cnt;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_pc, ex_target, ex_pred_taken, br_less, br_equal,
        input  pred_taken, br_unsigned, redirect_valid, redirect_pc,
               illegal_br, mispredict_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_pc, ex_target, ex_pred_taken, br_less, br_equal,
        output pred_taken, br_unsigned, redirect_valid, redirect_pc,
               illegal_br, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves EX-stage branches/jumps, issues registered PC redirects with a two-cycle
// shadow, and maintains a bimodal table of 2-bit predictor counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | accepting EX resolutions
// S_SHADOW1 | first cycle after a redirect; EX holds a wrong-path instr
// S_SHADOW2 | second wrong-path cycle; EX inputs still ignored
module branch_resolver #(
    parameter int BHT_ENTRIES = 16
) (
    input logic         clk,
    input logic         rst_n,
    branch_resolver_if.slave br_if
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHADOW1 = 2'd1,
        S_SHADOW2 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     bht_q [BHT_ENTRIES];
    logic           redirect_valid_q, redirect_valid_d;
    logic [31:0]    redirect_pc_q, redirect_pc_d;
    logic           illegal_br_q, illegal_br_d;
    logic [15:0]    mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX-1:0] if_idx;
    logic [IDX-1:0] ex_idx;
    logic           taken;
    logic           illegal_f3;
    logic           resolve_br;
    logic [1:0]     ctr_cur;
    logic [1:0]     ctr_next;
    logic [31:0]    pc_plus4;

    assign if_idx   = br_if.if_pc[IDX+1:2];
    assign ex_idx   = br_if.ex_pc[IDX+1:2];
    assign pc_plus4 = br_if.ex_pc + 32'd4;

    assign br_if.pred_taken     = bht_q[if_idx][1];
    assign br_if.br_unsigned    = br_if.ex_funct3[1];
    assign br_if.redirect_valid = redirect_valid_q;
    assign br_if.redirect_pc    = redirect_pc_q;
    assign br_if.illegal_br     = illegal_br_q;
    assign br_if.mispredict_cnt = mispredict_cnt_q;

    always_comb begin
        taken      = 1'b0;
        illegal_f3 = 1'b0;
        case (br_if.ex_funct3)
            3'b000:          taken = br_if.br_equal;
            3'b001:          taken = !br_if.br_equal;
            3'b100, 3'b110:  taken = br_if.br_less;
            3'b101, 3'b111:  taken = !br_if.br_less;
            default:         illegal_f3 = 1'b1;
        endcase
    end

    always_comb begin
        ctr_cur  = bht_q[ex_idx];
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        state_d          = state_q;
        resolve_br       = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        illegal_br_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_if.ex_valid) begin
                    // Jumps win over the branch flag and never touch the BHT.
                    if (br_if.ex_is_jump) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = {br_if.ex_target[31:1], 1'b0};
                    end else if (br_if.ex_is_branch) begin
                        resolve_br   = 1'b1;
                        illegal_br_d = illegal_f3;
                        if (taken != br_if.ex_pred_taken) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = taken ? br_if.ex_target : pc_plus4;
                        end
                    end
                end
                if (redirect_valid_d) state_d = S_SHADOW1;
            end
            S_SHADOW1: state_d = S_SHADOW2;
            S_SHADOW2: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        if (redirect_valid_d && mispredict_cnt_q != 16'hFFFF)
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            illegal_br_q     <= 1'b0;
            mispredict_cnt_q <= 16'd0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_br_q     <= illegal_br_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Weakly-not-taken start point for every counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (resolve_br) begin
            bht_q[ex_idx] <= ctr_next;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized checks of branch_resolver against a behavioural model.
module tb_branch_resolver;
    localparam int ENTRIES = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_resolver_if bif();
    branch_resolver #(.BHT_ENTRIES(ENTRIES)) dut (.clk(clk), .rst_n(rst_n), .br_if(bif));

    int vec_cnt = 0;
    int err_cnt = 0;

    int          bht_m [ENTRIES];
    int          shadow_m;
    int          cnt_m;
    bit          exp_rv;
    bit          exp_ill;
    logic [31:0] exp_rpc;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
        shadow_m = 0;
        cnt_m    = 0;
        exp_rv   = 0;
        exp_ill  = 0;
    endtask

    task automatic count_redirect();
        if (cnt_m < 65535) cnt_m++;
    endtask

    // One clock of the reference behaviour, from the currently driven inputs.
    task automatic model_step();
        bit act;
        int i;
        exp_rv  = 0;
        exp_ill = 0;
        if (shadow_m > 0) begin
            shadow_m--;
        end else if (bif.ex_valid && bif.ex_is_jump) begin
            exp_rv  = 1;
            exp_rpc = bif.ex_target & 32'hFFFF_FFFE;
            count_redirect();
            shadow_m = 2;
        end else if (bif.ex_valid && bif.ex_is_branch) begin
            case (int'(bif.ex_funct3))
                0:       act = bif.br_equal;
                1:       act = !bif.br_equal;
                4, 6:    act = bif.br_less;
                5, 7:    act = !bif.br_less;
                default: begin act = 0; exp_ill = 1; end
            endcase
            i = idx_of(bif.ex_pc);
            if (act) bht_m[i] = (bht_m[i] == 3) ? 3 : bht_m[i] + 1;
            else     bht_m[i] = (bht_m[i] == 0) ? 0 : bht_m[i] - 1;
            if (act != bif.ex_pred_taken) begin
                exp_rv  = 1;
                exp_rpc = act ? bif.ex_target : bif.ex_pc + 32'd4;
                count_redirect();
                shadow_m = 2;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [31:0] ipc, input bit v, input bit br, input bit jmp,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit pt, input bit lt, input bit eq);
        bif.if_pc         = ipc;
        bif.ex_valid      = v;
        bif.ex_is_branch  = br;
        bif.ex_is_jump    = jmp;
        bif.ex_funct3     = f3;
        bif.ex_pc         = pc;
        bif.ex_target     = tgt;
        bif.ex_pred_taken = pt;
        bif.br_less       = lt;
        bif.br_equal      = eq;
        #1;
        chk_val("pred_taken", {31'd0, bif.pred_taken}, (bht_m[idx_of(ipc)] >= 2) ? 32'd1 : 32'd0);
        chk_val("br_unsigned", {31'd0, bif.br_unsigned}, {31'd0, f3[1]});
        model_step();
        @(posedge clk);
        #1;
        chk_val("redirect_valid", {31'd0, bif.redirect_valid}, {31'd0, exp_rv});
        chk_val("illegal_br", {31'd0, bif.illegal_br}, {31'd0, exp_ill});
        if (exp_rv) chk_val("redirect_pc", bif.redirect_pc, exp_rpc);
        chk_val("mispredict_cnt", {16'd0, bif.mispredict_cnt}, cnt_m);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(32'h0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk_val("rst redirect_valid", {31'd0, bif.redirect_valid}, 32'd0);
        chk_val("rst redirect_pc", bif.redirect_pc, 32'd0);
        chk_val("rst illegal_br", {31'd0, bif.illegal_br}, 32'd0);
        chk_val("rst mispredict_cnt", {16'd0, bif.mispredict_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bif.if_pc = 0; bif.ex_valid = 0; bif.ex_is_branch = 0; bif.ex_is_jump = 0;
        bif.ex_funct3 = 0; bif.ex_pc = 0; bif.ex_target = 0; bif.ex_pred_taken = 0;
        bif.br_less = 0; bif.br_equal = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Fresh table predicts not-taken
        cycle(32'h100, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // BEQ taken, predicted not-taken: redirect to target, counter 1->2
        cycle(32'h100, 1, 1, 0, 3'b000, 32'h100, 32'h200, 0, 0, 1);
        // Two shadow cycles with mispredicting branches must be ignored
        cycle(32'h100, 1, 1, 0, 3'b001, 32'h100, 32'h300, 1, 0, 1);
        cycle(32'h100, 1, 1, 0, 3'b000, 32'h100, 32'h300, 0, 0, 1);

        // BGEU taken, predicted taken: no redirect, counter 2->3, then saturates
        cycle(32'h100, 1, 1, 0, 3'b111, 32'h100, 32'h400, 1, 0, 0);
        cycle(32'h100, 1, 1, 0, 3'b111, 32'h100, 32'h400, 1, 0, 0);
        // Not-taken from 3 leaves the prediction taken (3->2)
        cycle(32'h100, 1, 1, 0, 3'b000, 32'h100, 32'h400, 1, 0, 0);
        idle(2);
        cycle(32'h100, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // BNE not taken at top of address space: fall-through wraps to 0
        cycle(32'hFFFF_FFFC, 1, 1, 0, 3'b001, 32'hFFFF_FFFC, 32'h800, 1, 0, 1);
        idle(2);

        // Illegal funct3 with not-taken prediction: pulse, no redirect
        cycle(32'h40, 1, 1, 0, 3'b010, 32'h40, 32'h900, 0, 1, 1);
        cycle(32'h40, 1, 1, 0, 3'b011, 32'h44, 32'h900, 0, 0, 0);
        idle(1);

        // Jump taking priority over branch, odd target bit cleared
        cycle(32'h0, 1, 1, 1, 3'b010, 32'h500, 32'h1235, 0, 0, 0);
        idle(2);

        // Counter saturation near the top
        force dut.mispredict_cnt_q = 16'hFFFE;
        #1;
        release dut.mispredict_cnt_q;
        cnt_m = 65534;
        cycle(32'h0, 1, 0, 1, 3'b000, 32'h600, 32'h700, 0, 0, 0);
        idle(2);
        cycle(32'h0, 1, 0, 1, 3'b000, 32'h600, 32'h700, 0, 0, 0);
        idle(2);

        // Reset during SHADOW1 discards the shadow
        cycle(32'h0, 1, 1, 0, 3'b000, 32'h20, 32'hA00, 0, 0, 1);
        apply_reset();
        cycle(32'h20, 1, 1, 0, 3'b000, 32'h20, 32'hA00, 0, 0, 1);
        idle(2);

        // Randomized traffic over a small PC window to exercise aliasing
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc_r, ipc_r;
            pc_r  = 32'h1000 + ($urandom_range(0, 31) << 2);
            ipc_r = ($urandom_range(0, 3) == 0) ? pc_r : 32'h1000 + ($urandom_range(0, 31) << 2);
            cycle(ipc_r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), pc_r,
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
